// File: rtl/regex_pkg.sv
// Shared definitions for the bit-serial regex matcher and its match reporter.
// The latency constant is tied to the matcher's char-stage register depth, so
// the matcher and the reporter cannot drift apart on alignment.
package regex_pkg;

    // Default width of the character-position counter / reported position.
    localparam int unsigned POS_W_DEF     = 16;
    // Default width of the match counter.
    localparam int unsigned CNT_W_DEF     = 16;
    // Cycles from char_valid (i_c presented) to the matcher's `o` for that char.
    localparam int unsigned MATCH_LAT_DEF = 1;

    typedef logic [POS_W_DEF-1:0] pos_t;

endpackage

// File: rtl/match_fifo.sv
// Synchronous FIFO for reported match positions.
// Head is read straight from the storage registers (no fall-through path from
// push_data), so a push into an empty FIFO becomes visible on the next cycle.
// A push while full is accepted only when a pop happens in the same cycle.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   flush        drops all contents (and any same-cycle push/pop)
//   push         push request; push_data is the entry
//   pop_req      consumer ready; pop happens when out_valid & pop_req
//   out_valid    FIFO non-empty
//   out_data     entry at the head
//   level        current occupancy, 0..DEPTH
//   full         level == DEPTH
//   dropped      push request rejected because the FIFO was full with no pop
module match_fifo
    import regex_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = POS_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop_req,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push_ok;

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign out_data  = mem[rd_ptr];

    assign pop       = out_valid & pop_req;
    // Full is not a blocker when the head leaves in the same cycle.
    assign push_ok   = push & (~full | pop);
    assign dropped   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/match_reporter.sv
// Downstream stage of the bit-serial regex matcher. Stamps each presented
// character with its 0-based stream position, delays the stamp to line up
// with the matcher output `o`, and queues the positions of detected matches
// for the host side. Keeps a saturating match count and a sticky overflow.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   stream_start  one-cycle pulse; restarts positions, counters and flushes
//   char_valid    a character is presented to the matcher this cycle
//   match         matcher output `o`
//   out_ready     consumer accepts out_pos this cycle
//   out_valid     FIFO non-empty
//   out_pos       position at the FIFO head
//   match_count   detections since stream start (saturating, includes drops)
//   fifo_level    FIFO occupancy
//   overflow      sticky: a detection was dropped on a full FIFO
module match_reporter
    import regex_pkg::*;
#(
    parameter int unsigned POS_W     = POS_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MATCH_LAT = MATCH_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stream_start,
    input  logic                   char_valid,
    input  logic                   match,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [POS_W-1:0]       out_pos,
    output logic [CNT_W-1:0]       match_count,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    logic [POS_W-1:0] pos;
    logic             pipe_v   [MATCH_LAT];
    logic [POS_W-1:0] pipe_pos [MATCH_LAT];
    logic             detect;
    logic             push;
    logic             dropped;
    logic             full;

    // Matcher output only counts when the aligned character slot was real.
    assign detect = pipe_v[MATCH_LAT-1] & match;
    // A restart discards anything still in flight from the old stream.
    assign push   = detect & ~stream_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            pos         <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
            for (int unsigned i = 0; i < MATCH_LAT; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_pos[i] <= '0;
            end
        end else if (stream_start) begin
            // A character presented with the restart pulse is stamped 0.
            pos         <= POS_W'(char_valid);
            match_count <= '0;
            overflow    <= 1'b0;
            pipe_v[0]   <= char_valid;
            pipe_pos[0] <= '0;
            for (int unsigned i = 1; i < MATCH_LAT; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_pos[i] <= '0;
            end
        end else begin
            if (char_valid) begin
                pos <= pos + POS_W'(1);
            end
            pipe_v[0]   <= char_valid;
            pipe_pos[0] <= pos;
            for (int unsigned i = 1; i < MATCH_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_pos[i] <= pipe_pos[i-1];
            end
            if (detect && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
            if (dropped) begin
                overflow <= 1'b1;
            end
        end
    end

    match_fifo #(
        .DEPTH (DEPTH),
        .W     (POS_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (stream_start),
        .push      (push),
        .push_data (pipe_pos[MATCH_LAT-1]),
        .pop_req   (out_ready),
        .out_valid (out_valid),
        .out_data  (out_pos),
        .level     (fifo_level),
        .full      (full),
        .dropped   (dropped)
    );

endmodule

// File: tb/tb_match_reporter.sv
module tb_match_reporter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Instance A: default parameters
    logic        a_start = 1'b0;
    logic        a_cv    = 1'b0;
    logic        a_match = 1'b0;
    logic        a_rdy   = 1'b0;
    logic        a_valid;
    logic [15:0] a_pos;
    logic [15:0] a_cnt;
    logic [3:0]  a_level;
    logic        a_ovf;

    // Instance B: narrow counters for wrap / saturation
    logic        b_start = 1'b0;
    logic        b_cv    = 1'b0;
    logic        b_match = 1'b0;
    logic        b_rdy   = 1'b0;
    logic        b_valid;
    logic [3:0]  b_pos;
    logic [1:0]  b_cnt;
    logic [3:0]  b_level;
    logic        b_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    match_reporter u_a (
        .clk          (clk),
        .reset        (reset),
        .stream_start (a_start),
        .char_valid   (a_cv),
        .match        (a_match),
        .out_ready    (a_rdy),
        .out_valid    (a_valid),
        .out_pos      (a_pos),
        .match_count  (a_cnt),
        .fifo_level   (a_level),
        .overflow     (a_ovf)
    );

    match_reporter #(
        .POS_W (4),
        .CNT_W (2)
    ) u_b (
        .clk          (clk),
        .reset        (reset),
        .stream_start (b_start),
        .char_valid   (b_cv),
        .match        (b_match),
        .out_ready    (b_rdy),
        .out_valid    (b_valid),
        .out_pos      (b_pos),
        .match_count  (b_cnt),
        .fifo_level   (b_level),
        .overflow     (b_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of instance A stimulus; outputs sampled 1 time unit after the edge.
    task automatic step(input logic sv, input logic cv, input logic m, input logic rdy);
        a_start = sv;
        a_cv    = cv;
        a_match = m;
        a_rdy   = rdy;
        @(posedge clk);
        #1;
    endtask

    // Present n characters back-to-back; mbits[i] is the matcher output for
    // character i (arriving one cycle later). out_ready is raised only in
    // cycle rdy_c (-1 for never).
    task automatic run(input logic [63:0] mbits, input int n, input int rdy_c);
        for (int c = 0; c <= n; c++) begin
            step(1'b0, c < n, (c >= 1) ? mbits[c-1] : 1'b0, c == rdy_c);
        end
    endtask

    initial begin
        logic [63:0] in_bits;
        logic [63:0] mb;

        // Reset
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_valid", a_valid, 0);
        check("rst_pos",   a_pos,   0);
        check("rst_cnt",   a_cnt,   0);
        check("rst_level", a_level, 0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_b_valid", b_valid, 0);

        // Basic: match on char 20
        step(1'b1, 1'b0, 1'b0, 1'b0);
        mb = '0;
        mb[20] = 1'b1;
        run(mb, 21, -1);
        check("basic_valid", a_valid, 1);
        check("basic_pos",   a_pos,   20);
        check("basic_cnt",   a_cnt,   1);
        check("basic_level", a_level, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("basic_pop_valid", a_valid, 0);
        check("basic_pop_level", a_level, 0);
        // match with no aligned character is ignored
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("ignored_cnt",   a_cnt,   1);
        check("ignored_level", a_level, 0);

        // Integrated: model of (1|0)*1(1|0){20}; input bits 1,1,0,...
        step(1'b1, 1'b0, 1'b0, 1'b0);
        in_bits = '0;
        in_bits[0] = 1'b1;
        in_bits[1] = 1'b1;
        mb = '0;
        for (int i = 20; i < 22; i++) mb[i] = in_bits[i-20];
        run(mb, 22, -1);
        check("regex_level", a_level, 2);
        check("regex_cnt",   a_cnt,   2);
        check("regex_pos0",  a_pos,   20);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("regex_pos1",  a_pos,   21);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("regex_empty", a_valid, 0);

        // Overflow: detections at 30..39, no consumer
        step(1'b1, 1'b0, 1'b0, 1'b0);
        mb = '0;
        for (int i = 30; i < 40; i++) mb[i] = 1'b1;
        run(mb, 40, -1);
        check("ovf_level", a_level, 8);
        check("ovf_flag",  a_ovf,   1);
        check("ovf_cnt",   a_cnt,   10);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_hold_pos", a_pos, 30);
        for (int k = 0; k < 8; k++) begin
            check("ovf_drain_valid", a_valid, 1);
            check("ovf_drain_pos",   a_pos,   30 + k);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("ovf_drained", a_level, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ready_empty_level", a_level, 0);

        // stream_start with 3 queued entries and a match in flight
        mb = 64'h7;
        run(mb, 3, -1);
        check("ss_pre_level", a_level, 3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("ss_valid", a_valid, 0);
        check("ss_level", a_level, 0);
        check("ss_cnt",   a_cnt,   0);
        check("ss_ovf",   a_ovf,   0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("ss_stamp_valid", a_valid, 1);
        check("ss_stamp_pos",   a_pos,   0);
        check("ss_stamp_cnt",   a_cnt,   1);

        // Full FIFO with simultaneous push (pos 50) and pop
        step(1'b1, 1'b0, 1'b0, 1'b0);
        mb = '0;
        for (int i = 42; i < 51; i++) mb[i] = 1'b1;
        run(mb, 51, 51);
        check("pp_level", a_level, 8);
        check("pp_ovf",   a_ovf,   0);
        check("pp_cnt",   a_cnt,   9);
        for (int k = 0; k < 8; k++) begin
            check("pp_drain_pos", a_pos, 43 + k);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("pp_drained", a_valid, 0);

        // Wrap / saturate on instance B: detection on each of 17 chars
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_rdy   = 1'b1;
        for (int c = 0; c <= 17; c++) begin
            b_cv    = (c < 17);
            b_match = (c >= 1);
            @(posedge clk); #1;
            if (c >= 1) begin
                check("wrap_valid", b_valid, 1);
                check("wrap_pos",   b_pos,   (c - 1) % 16);
                check("wrap_cnt",   b_cnt,   (c < 3) ? c : 3);
            end
        end
        b_cv    = 1'b0;
        b_match = 1'b0;
        check("wrap_ovf", b_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/match_reporter.md
Name: match_reporter

Overview:
- Downstream stage of the bit-serial regex matcher (top `regex`, pattern (1|0)*1(1|0){20}).
- Consumes the matcher's per-character match output `o` and tags each match with the 0-based index of the character that completed it.
- Buffers match positions in a small FIFO with a valid/ready output for the host/CSR side, and keeps a saturating match count plus a sticky overflow flag.

Parameters:
- POS_W, 16, width of character-position counter and reported position.
- CNT_W, 16, width of match counter.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- MATCH_LAT, 1, cycles from char_valid to the corresponding matcher `o`; at least 1.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- stream_start  in  1  one-cycle pulse; begins a new stream.
- char_valid  in  1  a character (i_c) is presented to the matcher this cycle.
- match  in  1  matcher output `o`.
- out_ready  in  1  consumer accepts out_pos this cycle.
- out_valid  out  1  FIFO non-empty.
- out_pos  out  POS_W  position at FIFO head.
- match_count  out  CNT_W  matches detected since stream start, including dropped ones.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a match was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_pos=0, match_count=0, fifo_level=0, overflow=0. Position counter is 0 and the delay pipeline is empty.
- Position counter `pos`:
  - On char_valid, the current `pos` is stamped onto the character, then pos <= pos+1.
  - Wraps modulo 2^POS_W with no flag.
- Alignment pipeline:
  - Depth MATCH_LAT shift register of {char_valid, stamped pos}.
  - The delayed valid qualifies `match`. match while the delayed valid is 0 is ignored.
- Detection: delayed valid & match produces a push request carrying the delayed pos.
- match_count: increments on every detection; saturates at 2^CNT_W-1.
- FIFO:
  - Registered head; no fall-through. A push into an empty FIFO raises out_valid the next cycle.
  - Pop occurs when out_valid & out_ready.
  - Push is accepted if fifo_level<DEPTH, or if a pop happens in the same cycle (simultaneous push+pop at full is legal; level unchanged).
  - A push while full with no pop: entry dropped, overflow <= 1, match_count still increments.
  - out_pos is held stable while out_valid & !out_ready.
  - out_ready while empty has no effect.
- stream_start:
  - Has priority over every other event except reset.
  - Next cycle: pos=0 (or 1 if char_valid in the same cycle; that character is stamped 0), match_count=0, overflow=0.
  - FIFO is flushed (level 0, out_valid 0) and the delay pipeline is cleared. Any match in flight from the old stream is discarded.
  - A pop in the same cycle is discarded with the flush.
- Reset mid-operation: same effect as stream_start plus all outputs returned to reset values. In-flight data is lost.
- Latency: from the matcher `o` cycle to out_valid is 1 cycle when the FIFO is empty.

Decomposition:
- Shared package `regex_pkg`:
  - POS_W/CNT_W defaults.
  - MATCH_LAT constant tied to the matcher's char-stage register depth, so the matcher and reporter stay consistent.
  - typedef pos_t = logic [POS_W-1:0].
- One natural sub-module: `match_fifo` (sync FIFO, DEPTH x POS_W, with level, full/empty, and the push-on-full-with-pop rule).
- Pos counter, alignment pipeline, counter and overflow stay in the top.

Test Plan:
- Basic: reset, stream_start, then 21 chars with match driven high only in the cycle aligned to char index 20 (MATCH_LAT=1) -> out_valid next cycle, out_pos=20, match_count=1, fifo_level=1; out_ready pop -> out_valid=0.
- Integrated with `regex`: feed bits 1 then 20 zeros, then 1 -> exactly one entry, out_pos=20. A 1 at index 1 followed by 20 more chars -> second entry out_pos=21.
- Backpressure/overflow, DEPTH=8, out_ready=0: 10 consecutive detections at pos 30..39 -> fifo_level=8, overflow=1, match_count=10. Drain yields 30..37 in order.
- Full with simultaneous push+pop: FIFO full, out_ready=1 in the same cycle as a detection at pos 50 -> level stays 8, overflow stays 0, pos 50 appears last in the drain.
- stream_start with 3 entries queued and a match in flight -> next cycle out_valid=0, level=0, match_count=0, overflow=0. The in-flight match is not pushed; the next char is stamped 0.
- Wrap/saturate, POS_W=4, CNT_W=2: 17 chars with a detection on every char -> positions run 0..15 then 0; match_count holds at 3.
